csa_rr_sched: RTL and testbench
===============================

Name: csa_rr_sched

Overview:
- Round-robin scheduler that shares one 3-operand carry-save adder datapath (a + b + c_in, WIDTH-bit operands) between NUM_REQ independent requesters.
- Each requester presents an operand triple with a valid/ready handshake.
- The scheduler grants one requester per cycle, registers the sum in a single-entry output stage, and returns it tagged with the requester ID over a valid/ready result interface.
- It sits between the operand producers and the downstream consumer of sums.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; sum width is WIDTH+1
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operand triple valid
- req_a  input  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand b, same packing
- req_c  input  NUM_REQ*WIDTH  operand c_in, same packing
- req_ready  output  NUM_REQ  one-hot (or zero) accept strobe
- res_valid  output  1  result register holds a valid sum
- res_ready  input  1  downstream accepts the result
- res_sum  output  WIDTH+1  (a+b+c) mod 2^(WIDTH+1)
- res_ovf  output  1  bit WIDTH+1 of the true sum (the sum did not fit in WIDTH+1 bits)
- res_id  output  ID_W  index of the requester that produced res_sum
- op_count  output  CNT_W  saturating count of results consumed downstream

Behaviour:
- Reset (async assert, sync release):
  - res_valid=0, res_sum=0, res_ovf=0, res_id=0, op_count=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - req_ready is forced to 0 while rst is high.
- Output stage states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- can_accept = EMPTY, or (FULL and res_ready). This allows a full-throughput handoff in the same cycle.
- Arbitration (combinational, same cycle):
  - Scan from last_grant+1 modulo NUM_REQ and pick the first i with req_valid[i].
  - req_ready[i]=1 only for that i, and only when can_accept.
  - All other bits are 0.
  - With no valid requester, req_ready=0.
- Transfer: a transfer occurs on a rising edge where req_valid[i] & req_ready[i]. On that edge:
  - Full sum = a+b+c is computed at WIDTH+2 bits.
  - res_sum ← low WIDTH+1 bits; res_ovf ← bit WIDTH+1; res_id ← i.
  - Output stage goes to FULL; last_grant ← i.
- Latency: exactly 1 cycle from accept edge to res_valid=1 with the data.
- Result hold: while res_valid=1 and res_ready=0, res_sum/res_ovf/res_id are stable and req_ready=0.
- Drain: res_valid & res_ready with no new transfer takes the stage to EMPTY. res_sum/res_id keep their last values; they are don't-care while invalid.
- Simultaneous drain and accept: the stage stays FULL and the new data replaces the old on the same edge.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- last_grant changes only on a transfer.
- op_count increments on each res_valid & res_ready edge and saturates at 2^CNT_W-1.
- Requesters must hold operands stable while req_valid is high and not yet accepted. The scheduler samples operands only on the accept edge.
- Reset mid-operation discards any pending result, with no output glitch beyond the reset values above.

Decomposition:
- Shared package csa_pkg:
  - Default WIDTH, NUM_REQ and CNT_W constants.
  - Output-stage state enum {ST_EMPTY, ST_FULL}.
  - Function rr_pick(valid, last) returning the grant index plus a found flag.
- One natural sub-module: csa_rr_arb, the pure combinational round-robin arbiter (valid vector, last_grant, enable → one-hot grant, index).
- The adder is instantiated inline as the shared 3-operand datapath.

Test Plan:
- Reset check: rst=1 with all req_valid=1 → req_ready=0, res_valid=0, op_count=0. After release, req_ready=4'b0001 in the first cycle.
- Single op: req0 a=8'hFF, b=8'hFF, c=8'hFF, res_ready=1 → next cycle res_valid=1, res_sum=9'h0FD, res_ovf=1, res_id=0. With a=1, b=2, c=3 → res_sum=6, res_ovf=0.
- Round-robin: all four req_valid held high, res_ready=1 → grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle, op_count=5 after 5 drains.
- Backpressure: res_ready=0 for 3 cycles after the first result → res_sum/res_id stable, req_ready=0. When res_ready rises, the next requester is accepted the same cycle with no loss or duplication.
- Sparse/skip: only req2 and req0 valid, last_grant=0 → grant req2, then req0. A requester dropping valid is skipped without a bubble.
- Mid-op reset: assert rst while FULL and res_ready=0 → res_valid=0 immediately (async). After release, priority restarts at requester 0.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and helpers for the round-robin scheduler that feeds the
// 3-operand carry-save adder.
package csa_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} ostate_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First valid requester strictly after 'last', wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   last,
                                    input int                 n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(last) + k) % n;
      if (k <= n && !p.found && valid[j]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/csa_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant gated by enable.
module csa_rr_arb
  import csa_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);
  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pk;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
  end

  assign pk    = rr_pick(valid_ext, IDX_W'(last_grant), NUM_REQ);
  assign found = pk.found;
  assign idx   = ID_W'(pk.idx);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign grant[g] = en && pk.found && (pk.idx == IDX_W'(g));
  end
endmodule

// File: rtl/csa_rr_sched.sv
// Round-robin scheduler sharing one a+b+c carry-save adder between NUM_REQ
// requesters, with a single-entry registered result stage.
module csa_rr_sched
  import csa_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH:0]           res_sum,
  output logic                     res_ovf,
  output logic [ID_W-1:0]          res_id,
  output logic [CNT_W-1:0]         op_count
);
  ostate_e          st, st_nxt;
  logic [ID_W-1:0]  last_grant, gidx;
  logic             gfound, can_accept, xfer, drain;
  logic [WIDTH-1:0] a_sel, b_sel, c_sel, s_vec, c_vec;
  logic [WIDTH+1:0] full_sum;

  assign res_valid  = (st == ST_FULL);
  assign can_accept = (st == ST_EMPTY) || res_ready;
  assign drain      = res_valid && res_ready;

  csa_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .en         (can_accept && !rst),
    .grant      (req_ready),
    .idx        (gidx),
    .found      (gfound)
  );

  assign xfer = gfound && can_accept && !rst;

  // Shared datapath: 3:2 compress, then one carry-propagate add.
  assign a_sel    = req_a[gidx*WIDTH +: WIDTH];
  assign b_sel    = req_b[gidx*WIDTH +: WIDTH];
  assign c_sel    = req_c[gidx*WIDTH +: WIDTH];
  assign s_vec    = a_sel ^ b_sel ^ c_sel;
  assign c_vec    = (a_sel & b_sel) | (a_sel & c_sel) | (b_sel & c_sel);
  assign full_sum = {2'b00, s_vec} + {1'b0, c_vec, 1'b0};

  always_comb begin
    st_nxt = st;
    if (xfer)       st_nxt = ST_FULL;
    else if (drain) st_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_EMPTY;
    else     st <= st_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum    <= '0;
      res_ovf    <= 1'b0;
      res_id     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      res_sum    <= full_sum[WIDTH:0];
      res_ovf    <= full_sum[WIDTH+1];
      res_id     <= gidx;
      last_grant <= gidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        op_count <= '0;
    else if (drain && op_count != '1) op_count <= op_count + 1'b1;
  end
endmodule

// File: tb/tb_csa_rr_sched.sv
// Directed bench for csa_rr_sched: expected results queued at issue time,
// a negedge monitor pops and compares every consumed result.
module tb_csa_rr_sched;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W:0] sum;
    logic       ovf;
    logic [1:0] id;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic [N-1:0]   req_ready;
  logic           res_valid, res_ready, res_ovf;
  logic [W:0]     res_sum;
  logic [1:0]     res_id;
  logic [15:0]    op_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  csa_rr_sched #(.NUM_REQ(N), .WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_ovf(res_ovf), .res_id(res_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  task automatic push(input logic [W:0] s, input logic o, input logic [1:0] id);
    exp_t e;
    e.sum = s; e.ovf = o; e.id = id;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: a result is consumed on the next edge when valid&ready.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_id=%0d actual_sum=%0h required=none", res_id, res_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_sum", 32'(res_sum), 32'(mon_e.sum));
        chk("sb_ovf", 32'(res_ovf), 32'(mon_e.ovf));
        chk("sb_id",  32'(res_id),  32'(mon_e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '1; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    set_op(0, 8'hFF, 8'hFF, 8'hFF);

    // Reset state with all requesters valid
    repeat (2) cyc();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_op_count",  32'(op_count),  32'h0);
    chk("rst_res_sum",   32'(res_sum),   32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);

    // Single ops on requester 0: max operands, then small ones
    push(9'h0FD, 1'b1, 2'd0);
    cyc();
    req_valid = 4'b0001; res_ready = 1'b1;
    chk("single_valid", 32'(res_valid), 32'h1);
    set_op(0, 8'd1, 8'd2, 8'd3);
    push(9'h006, 1'b0, 2'd0);
    cyc();
    req_valid = '0;
    chk("single_cnt1", 32'(op_count), 32'd1);
    cyc();
    chk("single_cnt2", 32'(op_count), 32'd2);
    chk("single_empty", 32'(res_valid), 32'h0);

    // Round robin from a fresh reset: 0,1,2,3,0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_op(0, 8'd10, 8'd20, 8'd30);
    set_op(1, 8'h80, 8'h80, 8'h80);
    set_op(2, 8'hFF, 8'hFF, 8'h00);
    set_op(3, 8'hFF, 8'hFF, 8'h02);
    push(9'h03C, 1'b0, 2'd0);
    push(9'h180, 1'b0, 2'd1);
    push(9'h1FE, 1'b0, 2'd2);
    push(9'h000, 1'b1, 2'd3);
    push(9'h03C, 1'b0, 2'd0);
    req_valid = '1; res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      cyc();
    end
    req_valid = '0;
    cyc();
    chk("rr_op_count", 32'(op_count), 32'd5);
    chk("rr_empty", 32'(res_valid), 32'h0);

    // Backpressure: result from req1 held for 3 cycles
    res_ready = 1'b0; req_valid = '1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      chk($sformatf("bp_id%0d", k),    32'(res_id),    32'd1);
      chk($sformatf("bp_sum%0d", k),   32'(res_sum),   32'h180);
      chk($sformatf("bp_vld%0d", k),   32'(res_valid), 32'h1);
      cyc();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'b0100);
    push(9'h180, 1'b0, 2'd1);
    push(9'h1FE, 1'b0, 2'd2);
    cyc();
    req_valid = '0;
    cyc();
    chk("bp_op_count", 32'(op_count), 32'd7);

    // Sparse: put last_grant on 0, then req0+req2 valid
    req_valid = 4'b0001;
    push(9'h03C, 1'b0, 2'd0);
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'b0101;
    #1;
    chk("sparse_first", 32'(req_ready), 32'b0100);
    push(9'h1FE, 1'b0, 2'd2);
    cyc();
    req_valid = 4'b0001;
    #1;
    chk("sparse_second", 32'(req_ready), 32'b0001);
    push(9'h03C, 1'b0, 2'd0);
    cyc();
    req_valid = '0;
    cyc();

    // Mid-operation reset while result is held
    res_ready = 1'b0; req_valid = 4'b0010;
    cyc();
    req_valid = '1;
    chk("mid_full", 32'(res_valid), 32'h1);
    chk("mid_id",   32'(res_id),    32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_cnt",   32'(op_count),  32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_prio", 32'(req_ready), 32'h1);
    req_valid = '0; res_ready = 1'b1;
    repeat (3) cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
